// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_gen_pkg
//   Shared types and helpers for the serial pattern stream generator.
//   - state_t    : transmitter FSM state (IDLE=0, SHIFT=1, DONE=2)
//   - cnt_width(): width of the bit counter / pair counter for a given WIDTH
// -----------------------------------------------------------------------------
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Enough bits to hold any value 0..width (bit index and pair count).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/pattern_stream_gen_pair_counter.sv
// -----------------------------------------------------------------------------
// pair_counter
//   Golden model of a two-consecutive-ones detector: remembers the previous
//   serial bit and counts positions where the current and previous bits are
//   both 1. The count saturates at all-ones.
// Ports:
//   Clock, Resetn : clock, asynchronous active-low reset
//   i_clear       : synchronous clear of prev and count (accepted start)
//   i_enable      : a stream bit is present on i_bit this cycle
//   i_bit         : current serial bit
//   o_count       : number of consecutive-ones pairs seen so far
// -----------------------------------------------------------------------------
module pair_counter
  import pattern_gen_pkg::*;
#(
  parameter int CNT_W = cnt_width(DEFAULT_WIDTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_bit,
  output logic [CNT_W-1:0] o_count
);

  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_pair;
  logic             w_saturated;

  assign w_pair      = i_bit & r_prev;
  assign w_saturated = (r_count == '1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (i_clear) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (i_enable) begin
      r_prev <= i_bit;
      if (w_pair && !w_saturated) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pattern_stream_gen.sv
// -----------------------------------------------------------------------------
// pattern_stream_gen
//   Serial stimulus transmitter for single-bit sequence detectors. Loads a
//   WIDTH-bit pattern on an accepted start, shifts it out MSB-first on w (one
//   bit per Clock, framed by w_valid), pulses done once afterwards, and reports
//   how many consecutive-ones pairs the stream contained.
// Ports:
//   Clock, Resetn : rising-edge clock, asynchronous active-low reset
//   start         : transmit request, honoured only in IDLE
//   pattern       : bits to send, captured on the accepted start edge
//   w             : serial data (0 whenever w_valid=0)
//   w_valid       : a pattern bit is on w
//   busy          : SHIFT or DONE
//   done          : one-cycle pulse after the last bit
//   ones_pairs    : consecutive-ones pair count of the current/last stream
//   repeat_i      : only with PATTERN_GEN_REPEAT_EN; loop the pattern with no
//                   gap while high at the last bit
// Build option: PATTERN_GEN_REPEAT_EN enables the repeat_i looping feature.
// -----------------------------------------------------------------------------
module pattern_stream_gen
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
`ifdef PATTERN_GEN_REPEAT_EN
  input  logic             repeat_i,
`endif
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_pairs
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bitcnt;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_in_shift;

  assign w_in_shift = (r_state == ST_SHIFT);
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_last_bit = (r_bitcnt == '0);

`ifdef PATTERN_GEN_REPEAT_EN
  // Copy of the captured pattern, reloaded into the shifter on each loop.
  logic [WIDTH-1:0] r_pattern;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pattern <= '0;
    end else if (w_accept) begin
      r_pattern <= pattern;
    end
  end
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shreg  <= pattern;
            r_bitcnt <= CNT_W'(WIDTH - 1);
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
`ifdef PATTERN_GEN_REPEAT_EN
            if (repeat_i) begin
              r_shreg  <= r_pattern;
              r_bitcnt <= CNT_W'(WIDTH - 1);
            end else begin
              r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
              r_state <= ST_DONE;
            end
`else
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_state <= ST_DONE;
`endif
          end else begin
            r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bitcnt <= r_bitcnt - 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gate w so a downstream detector only ever sees 0s between streams.
  assign w       = w_in_shift & r_shreg[WIDTH-1];
  assign w_valid = w_in_shift;
  assign busy    = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign done    = (r_state == ST_DONE);

  pair_counter #(
    .CNT_W(CNT_W)
  ) u_pair_counter (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .i_clear (w_accept),
    .i_enable(w_in_shift),
    .i_bit   (w),
    .o_count (ones_pairs)
  );

endmodule

// File: tb/tb_pattern_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_stream_gen
//   Directed bench for pattern_stream_gen (WIDTH=8). A two-consecutive-ones
//   Mealy detector model watches w and its assertions are compared with the
//   expected pair count of each stream.
// -----------------------------------------------------------------------------
module tb_pattern_stream_gen;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             Clock;
  logic             Resetn;
  logic             start;
  logic [WIDTH-1:0] pattern;
`ifdef PATTERN_GEN_REPEAT_EN
  logic             repeat_i;
`endif
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ones_pairs;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_stream_gen #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .start     (start),
    .pattern   (pattern),
`ifdef PATTERN_GEN_REPEAT_EN
    .repeat_i  (repeat_i),
`endif
    .w         (w),
    .w_valid   (w_valid),
    .busy      (busy),
    .done      (done),
    .ones_pairs(ones_pairs)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Two-consecutive-ones Mealy detector: z = w & y, y = previous w.
  logic det_y;
  int   z_total = 0;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      det_y <= 1'b0;
    end else begin
      if (w && det_y) z_total <= z_total + 1;
      det_y <= w;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] pat;
    int               exp_pairs;
    int               exp_z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic launch(input logic [WIDTH-1:0] pat);
    pattern = pat;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    pattern = ~pat;  // changes after capture must have no effect
  endtask

  // Entered right after the accepting edge; leaves the DUT in its DONE cycle.
  // poke >= 0 pulses start (with a different pattern) at that bit index.
  task automatic run_stream(input logic [WIDTH-1:0] pat, input int exp_pairs,
                            input int exp_z, input int poke);
    int z0;
    z0 = z_total;
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("w bit%0d of %h", i, pat), w, pat[WIDTH-1-i]);
      check("w_valid in shift", w_valid, 1);
      check("busy in shift", busy, 1);
      check("done in shift", done, 0);
      if (i == poke) begin
        start   = 1'b1;
        pattern = ~pat;
      end
      tick();
      start = 1'b0;
    end
    check("done pulse", done, 1);
    check("w_valid in done", w_valid, 0);
    check("w zero in done", w, 0);
    check("busy in done", busy, 1);
    check($sformatf("ones_pairs of %h", pat), ones_pairs, exp_pairs);
    check($sformatf("detector z of %h", pat), z_total - z0, exp_z);
  endtask

  task automatic send(input logic [WIDTH-1:0] pat, input int exp_pairs, input int exp_z);
    launch(pat);
    run_stream(pat, exp_pairs, exp_z, -1);
    tick();
    check("done one cycle", done, 0);
    check("busy back in idle", busy, 0);
    check("w_valid in idle", w_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'b1101_1110, 4, 4};
    vecs[1] = '{8'b1010_1010, 0, 0};
    vecs[2] = '{8'hFF,        7, 7};
    vecs[3] = '{8'h00,        0, 0};
    vecs[4] = '{8'b1000_0001, 0, 0};
    vecs[5] = '{8'b0110_0110, 2, 2};
    vecs[6] = '{8'b1110_0111, 4, 4};
    vecs[7] = '{8'b0011_1100, 3, 3};

    // Reset held with start asserted: everything stays quiet.
    Resetn  = 1'b0;
    start   = 1'b1;
    pattern = 8'hFF;
`ifdef PATTERN_GEN_REPEAT_EN
    repeat_i = 1'b0;
`endif
    repeat (3) tick();
    check("reset w", w, 0);
    check("reset w_valid", w_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ones_pairs", ones_pairs, 0);
    start = 1'b0;
    #2 Resetn = 1'b1;
    tick();
    check("idle after reset w_valid", w_valid, 0);
    check("idle after reset busy", busy, 0);

    // Table of single streams.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].pat, vecs[v].exp_pairs, vecs[v].exp_z);
    end
    repeat (3) tick();
    check("ones_pairs held in idle", ones_pairs, 3);

    // Reset after the 3rd bit of 8'hFF abandons the stream.
    launch(8'hFF);
    tick();
    tick();
    tick();
    check("mid-stream w_valid", w_valid, 1);
    check("mid-stream ones_pairs", ones_pairs, 2);
    Resetn = 1'b0;
    #1;
    check("async reset w", w, 0);
    check("async reset w_valid", w_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset ones_pairs", ones_pairs, 0);
    #2 Resetn = 1'b1;
    tick();
    send(8'b0101_1010, 1, 1);

    // start pulsed during SHIFT and held through DONE: only IDLE accepts it.
    launch(8'b1100_0011);
    run_stream(8'b1100_0011, 2, 2, 3);
    start   = 1'b1;
    pattern = 8'hFF;
    tick();
    check("start in done ignored busy", busy, 0);
    check("start in done ignored w_valid", w_valid, 0);
    tick();
    start = 1'b0;
    run_stream(8'hFF, 7, 7, -1);
    tick();
    check("idle after poke test", busy, 0);

`ifdef PATTERN_GEN_REPEAT_EN
    // Two contiguous passes of 8'b1000_0001; the pair across the wrap counts.
    begin
      int z0;
      logic [WIDTH-1:0] rp;
      rp = 8'b1000_0001;
      repeat_i = 1'b1;
      launch(rp);
      z0 = z_total;
      for (int i = 0; i < 2 * WIDTH; i++) begin
        if (i == WIDTH) repeat_i = 1'b0;
        check($sformatf("repeat w bit%0d", i), w, rp[WIDTH-1-(i % WIDTH)]);
        check("repeat w_valid", w_valid, 1);
        check("repeat no done", done, 0);
        tick();
      end
      check("repeat done pulse", done, 1);
      check("repeat ones_pairs", ones_pairs, 1);
      check("repeat detector z", z_total - z0, 1);
      tick();
      check("repeat back idle", busy, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
